// File: rtl/btn_debounce.sv
// Push-button conditioner: per channel a multi-flop synchroniser, a
// counter-based debounce FSM, a registered debounced level and one-cycle
// rise/fall pulses. Defining LONG_PRESS_EN adds a per-channel hold counter
// that emits a one-cycle btn_long pulse after LONG_CNT held cycles.
module btn_debounce #(
    parameter int unsigned N_BTN        = 2,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CNT = 1_000_000,
    parameter int unsigned LONG_CNT     = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] btn_long
);

    typedef enum logic [1:0] {
        StReleased,
        StPressPend,
        StPressed,
        StReleasePend
    } state_e;

    localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
    // cnt holds the number of agreeing samples already seen; the sample that
    // arrives while cnt == DEBOUNCE_CNT-1 completes the stable window.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [N_BTN-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_BTN-1:0]                  s;
    state_e                            state_q [N_BTN];
    state_e                            state_d [N_BTN];
    logic [CntW-1:0]                   cnt_q   [N_BTN];
    logic [CntW-1:0]                   cnt_d   [N_BTN];
    logic [N_BTN-1:0]                  level_q, level_d;
    logic [N_BTN-1:0]                  rise_q, rise_d;
    logic [N_BTN-1:0]                  fall_q, fall_d;

    // Synchroniser shift: raw pin enters bit 0, synced value leaves the top bit.
    always_comb begin
        for (int i = 0; i < int'(N_BTN); i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
            s[i]      = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debounce FSM next-state, counter and pulse decode per channel.
    always_comb begin
        for (int i = 0; i < int'(N_BTN); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            unique case (state_q[i])
                StReleased: begin
                    if (s[i]) begin
                        // A one-sample window accepts the press immediately.
                        if (DEBOUNCE_CNT == 1) begin
                            state_d[i] = StPressed;
                            cnt_d[i]   = '0;
                            rise_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = StPressPend;
                            cnt_d[i]   = CntOne;
                        end
                    end
                end
                StPressPend: begin
                    if (!s[i]) begin
                        state_d[i] = StReleased;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StPressed;
                        cnt_d[i]   = '0;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StPressed: begin
                    if (!s[i]) begin
                        if (DEBOUNCE_CNT == 1) begin
                            state_d[i] = StReleased;
                            cnt_d[i]   = '0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = StReleasePend;
                            cnt_d[i]   = CntOne;
                        end
                    end
                end
                StReleasePend: begin
                    if (s[i]) begin
                        state_d[i] = StPressed;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StReleased;
                        cnt_d[i]   = '0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = StReleased;
                    cnt_d[i]   = '0;
                end
            endcase
            // Level follows the next state so it moves on the same edge as its pulse.
            level_d[i] = (state_d[i] == StPressed) || (state_d[i] == StReleasePend);
        end
    end

    // Synchroniser, FSM and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                state_q[i] <= StReleased;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned HoldW = $clog2(LONG_CNT + 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CNT);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CNT - 1);

    logic [HoldW-1:0] hold_q [N_BTN];
    logic [HoldW-1:0] hold_d [N_BTN];
    logic [N_BTN-1:0] long_q, long_d;

    // Hold counter: cleared on accept/release, saturating count while pressed.
    always_comb begin
        for (int i = 0; i < int'(N_BTN); i++) begin
            hold_d[i] = hold_q[i];
            long_d[i] = 1'b0;
            if (rise_d[i] || fall_d[i]) begin
                // A release on the reaching edge wins: no long pulse for it.
                hold_d[i] = '0;
            end else if (level_q[i] && (hold_q[i] != HoldMax)) begin
                hold_d[i] = hold_q[i] + HoldW'(1);
                long_d[i] = (hold_q[i] == HoldLast);
            end
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_q <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            long_q <= long_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign btn_long = long_q;
`else
    logic unused_long_cnt;
    assign unused_long_cnt = ^LONG_CNT;
    assign btn_long        = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: a window-based reference model pushes the
// expected outputs at every clock edge, a negedge monitor pops and compares.
module tb_btn_debounce;

    localparam int unsigned N     = 2;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 4;
    localparam int unsigned LONGC = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_rise, btn_fall, btn_long;

    btn_debounce #(
        .N_BTN       (N),
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_CNT(DEB),
        .LONG_CNT    (LONGC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] lng;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: the synced stream is the raw input delayed SYNC edges;
    // the level flips when the last DEB synced samples all disagree with it.
    logic [SYNC-1:0] m_sync [N];
    logic [DEB-1:0]  m_hist [N];
    logic            m_lvl  [N];
    int              m_rise_edge [N];
    int              m_edge;

    always @(posedge clk) begin : model
        exp_t e;
        logic s, r, f, l;
        e = '0;
        if (!rst_n) begin
            m_edge = 0;
            for (int c = 0; c < int'(N); c++) begin
                m_sync[c]      = '0;
                m_hist[c]      = '0;
                m_lvl[c]       = 1'b0;
                m_rise_edge[c] = -1000;
            end
        end else begin
            for (int c = 0; c < int'(N); c++) begin
                s         = m_sync[c][SYNC-1];
                m_sync[c] = {m_sync[c][SYNC-2:0], btn_raw[c]};
                m_hist[c] = {m_hist[c][DEB-2:0], s};
                r = !m_lvl[c] && (&m_hist[c]);
                f = m_lvl[c] && !(|m_hist[c]);
                l = 1'b0;
`ifdef LONG_PRESS_EN
                l = m_lvl[c] && !f && (m_edge == m_rise_edge[c] + int'(LONGC));
`endif
                if (r) begin
                    m_lvl[c]       = 1'b1;
                    m_rise_edge[c] = m_edge;
                end
                if (f) m_lvl[c] = 1'b0;
                e.lvl[c]  = m_lvl[c];
                e.rise[c] = r;
                e.fall[c] = f;
                e.lng[c]  = l;
            end
            m_edge++;
        end
        sb_q.push_back(e);
    end

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t ex, got;
        if (sb_q.size() > 0) begin
            ex  = sb_q.pop_front();
            got = {btn_level, btn_rise, btn_fall, btn_long};
            n_vec++;
            if (got !== ex) begin
                n_err++;
                $display("FAIL outputs vec=%0d t=%0t got lvl=%b rise=%b fall=%b long=%b required lvl=%b rise=%b fall=%b long=%b",
                         n_vec, $time, got.lvl, got.rise, got.fall, got.lng,
                         ex.lvl, ex.rise, ex.fall, ex.lng);
            end
        end
    end

    task automatic drive(input logic [N-1:0] raw, input logic rn, input int unsigned n);
        btn_raw = raw;
        rst_n   = rn;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int unsigned  left [N];
        logic [N-1:0] r;
        logic         rn;
        rst_n   = 1'b0;
        btn_raw = '0;
        #1;
        // Reset with both buttons held, then debounce through release.
        drive(2'b11, 1'b0, 3);
        drive(2'b11, 1'b1, 12);
        drive(2'b00, 1'b1, 10);
        // Clean press on channel 1.
        drive(2'b10, 1'b1, 10);
        // Bounce on channel 0 while channel 1 stays pressed.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1'b1, 3);
            drive(2'b10, 1'b1, 1);
        end
        drive(2'b11, 1'b1, 10);
        // Release channel 1, then channel 0.
        drive(2'b01, 1'b1, 10);
        drive(2'b00, 1'b1, 10);
        // Reset in the middle of a pending press.
        drive(2'b01, 1'b1, 3);
        drive(2'b01, 1'b0, 1);
        drive(2'b01, 1'b1, 10);
        drive(2'b00, 1'b1, 10);
        // Long hold on channel 0.
        drive(2'b01, 1'b1, 30);
        drive(2'b00, 1'b1, 10);
        // Randomised run lengths around the debounce window, rare resets.
        r = '0;
        for (int c = 0; c < int'(N); c++) left[c] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < int'(N); c++) begin
                if (left[c] == 0) begin
                    r[c]    = ~r[c];
                    left[c] = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30)
                                                          : $urandom_range(1, 7);
                end
                left[c]--;
            end
            rn = ($urandom_range(0, 299) != 0);
            drive(r, rn, 1);
        end
        drive(2'b00, 1'b1, 12);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
